// File: rtl/vt52_pkg.sv
// vt52_pkg
// Shared definitions for the VT52 screen controller and the video generator:
// screen geometry, control codes, escape command letters, controller state
// and erase-mode enums, the screen RAM address map and the hardware-scroll
// row translation.
package vt52_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 24;
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    localparam logic [6:0] CR  = 7'h0D;
    localparam logic [6:0] LF  = 7'h0A;
    localparam logic [6:0] BS  = 7'h08;
    localparam logic [6:0] ESC = 7'h1B;

    localparam logic [6:0] FIRST_PRINT = 7'h20;
    localparam logic [6:0] LAST_PRINT  = 7'h7E;

    localparam logic [6:0] ESC_UP    = 7'h41;
    localparam logic [6:0] ESC_DOWN  = 7'h42;
    localparam logic [6:0] ESC_RIGHT = 7'h43;
    localparam logic [6:0] ESC_LEFT  = 7'h44;
    localparam logic [6:0] ESC_HOME  = 7'h48;
    localparam logic [6:0] ESC_EOS   = 7'h4A;
    localparam logic [6:0] ESC_EOL   = 7'h4B;
    localparam logic [6:0] ESC_POS   = 7'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_ESCY_ROW,
        ST_ESCY_COL,
        ST_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        ERASE_EOL,
        ERASE_EOS,
        ERASE_SCROLL
    } erase_mode_t;

    // Columns 64..79 do not fit the 6-bit column field, so they are folded
    // into the unused row codes 24..31 of the same RAM half.
    function automatic logic [10:0] vt52_addr(input logic [6:0] x, input logic [4:0] y);
        logic outside;
        outside = (y[4] & y[3]) | x[6];
        if (outside)
            return {y[0], 2'b11, y[2:1], y[4:3], x[3:0]};
        return {y[0], y[4:1], x[5:0]};
    endfunction

    // Logical row to physical row under the scroll pointer; the sum never
    // exceeds 46, so one conditional subtract replaces a modulo.
    function automatic logic [4:0] phys_row(input logic [4:0] top, input logic [4:0] row);
        logic [5:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (sum >= 6'd24)
            sum = sum - 6'd24;
        return sum[4:0];
    endfunction

endpackage

// File: rtl/vt52_clear_engine.sv
// vt52_clear_engine
// Walks the screen one cell per step from (x0, row0) to column 79 of the end
// row, producing the RAM address of the current cell.
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   start            load the start cell and end row from x0/row0/mode
//   step             advance one cell (asserted while the controller erases)
//   x0, row0         first cell, logical row
//   mode             erase mode; EOS runs to row 23, others stop at row0
//   topline          scroll pointer used to translate the logical row
//   done             current cell is the last one of the erase
//   wr_addr          RAM address of the current cell
module vt52_clear_engine
    import vt52_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic [6:0]  x0,
    input  logic [4:0]  row0,
    input  logic [1:0]  mode,
    input  logic [4:0]  topline,
    output logic        done,
    output logic [10:0] wr_addr
);

    logic [6:0] clr_x;
    logic [4:0] clr_row;
    logic [4:0] end_row;

    // Reset leaves the counters set up for a full-screen erase so the
    // power-up clear needs no separate start pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_x   <= '0;
            clr_row <= '0;
            end_row <= LAST_ROW;
        end else if (start) begin
            clr_x   <= x0;
            clr_row <= row0;
            end_row <= (mode == ERASE_EOS) ? LAST_ROW : row0;
        end else if (step) begin
            if (clr_x == LAST_COL) begin
                clr_x   <= '0;
                clr_row <= clr_row + 5'd1;
            end else begin
                clr_x <= clr_x + 7'd1;
            end
        end
    end

    assign done    = (clr_x == LAST_COL) && (clr_row == end_row);
    assign wr_addr = vt52_addr(clr_x, phys_row(topline, clr_row));

endmodule

// File: rtl/vt52_screen_ctrl.sv
// vt52_screen_ctrl
// Interprets the incoming character stream (printables, CR/LF/BS, VT52
// escape sequences), owns the cursor and the scroll pointer, and sequences
// every write into the 80x24 screen RAM, including scroll and erase fills.
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   char_in/char_valid   character stream; accepted when char_ready is high
//   char_ready, busy     ready to accept / erase in progress (complements)
//   curX, curY           cursor column and physical row for the video side
//   topline              physical row displayed at the top of the screen
//   mem_we/addr/wdata    registered screen RAM write port
module vt52_screen_ctrl
    import vt52_pkg::*;
#(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [6:0] BLANK          = 7'h20
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [6:0]  curX,
    output logic [4:0]  curY,
    output logic [4:0]  topline,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [6:0]  mem_wdata,
    output logic        busy
);

    state_t      state, state_n;
    logic [6:0]  cur_x, cur_x_n;
    logic [4:0]  cur_row, cur_row_n;
    logic [4:0]  topline_n;
    logic [6:0]  esc_row, esc_row_n;
    logic        we_n;
    logic [10:0] addr_n;
    logic [6:0]  wdata_n;
    logic [6:0]  esc_arg;
    logic [4:0]  cur_phys;
    logic        accept;

    logic        clr_start;
    logic [6:0]  clr_x0;
    logic [4:0]  clr_row0;
    erase_mode_t clr_mode;
    logic        clr_done;
    logic [10:0] clr_addr;

    assign char_ready = (state != ST_CLEAR);
    assign busy       = ~char_ready;
    assign accept     = char_valid && char_ready;
    assign cur_phys   = phys_row(topline, cur_row);
    assign curX       = cur_x;
    assign curY       = cur_phys;

    vt52_clear_engine u_clear (
        .clock   (clock),
        .reset   (reset),
        .start   (clr_start),
        .step    (state == ST_CLEAR),
        .x0      (clr_x0),
        .row0    (clr_row0),
        .mode    (clr_mode),
        .topline (topline),
        .done    (clr_done),
        .wr_addr (clr_addr)
    );

    // Next-state, cursor and write-port logic. Cursor moves happen on the
    // acceptance edge; the write they cause is registered on the same edge
    // so it shows up in the following cycle.
    always_comb begin
        state_n   = state;
        cur_x_n   = cur_x;
        cur_row_n = cur_row;
        topline_n = topline;
        esc_row_n = esc_row;
        we_n      = 1'b0;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        clr_start = 1'b0;
        clr_x0    = cur_x;
        clr_row0  = cur_row;
        clr_mode  = ERASE_EOL;
        esc_arg   = char_in - FIRST_PRINT;

        case (state)
            ST_CLEAR: begin
                we_n    = 1'b1;
                addr_n  = clr_addr;
                wdata_n = BLANK;
                if (clr_done)
                    state_n = ST_IDLE;
            end

            ST_IDLE: if (accept) begin
                if (char_in >= FIRST_PRINT && char_in <= LAST_PRINT) begin
                    we_n    = 1'b1;
                    addr_n  = vt52_addr(cur_x, cur_phys);
                    wdata_n = char_in;
                    if (cur_x != LAST_COL)
                        cur_x_n = cur_x + 7'd1;
                end else begin
                    case (char_in)
                        CR: cur_x_n = '0;
                        BS: if (cur_x != '0) cur_x_n = cur_x - 7'd1;
                        LF: begin
                            if (cur_row != LAST_ROW) begin
                                cur_row_n = cur_row + 5'd1;
                            end else begin
                                // Advancing topline turns the old top row
                                // into logical row 23, which is then blanked.
                                topline_n = (topline == LAST_ROW) ? 5'd0 : topline + 5'd1;
                                clr_start = 1'b1;
                                clr_x0    = '0;
                                clr_row0  = LAST_ROW;
                                clr_mode  = ERASE_SCROLL;
                                state_n   = ST_CLEAR;
                            end
                        end
                        ESC:     state_n = ST_ESC;
                        default: ;
                    endcase
                end
            end

            ST_ESC: if (accept) begin
                state_n = ST_IDLE;
                case (char_in)
                    ESC_UP:    if (cur_row != '0) cur_row_n = cur_row - 5'd1;
                    ESC_DOWN:  if (cur_row != LAST_ROW) cur_row_n = cur_row + 5'd1;
                    ESC_RIGHT: if (cur_x != LAST_COL) cur_x_n = cur_x + 7'd1;
                    ESC_LEFT:  if (cur_x != '0) cur_x_n = cur_x - 7'd1;
                    ESC_HOME: begin
                        cur_x_n   = '0;
                        cur_row_n = '0;
                    end
                    ESC_EOL: begin
                        clr_start = 1'b1;
                        clr_mode  = ERASE_EOL;
                        state_n   = ST_CLEAR;
                    end
                    ESC_EOS: begin
                        clr_start = 1'b1;
                        clr_mode  = ERASE_EOS;
                        state_n   = ST_CLEAR;
                    end
                    ESC_POS: state_n = ST_ESCY_ROW;
                    default: ;
                endcase
            end

            ST_ESCY_ROW: if (accept) begin
                esc_row_n = esc_arg;
                state_n   = ST_ESCY_COL;
            end

            // Out-of-range coordinates (including control codes, which wrap
            // to large values) leave that coordinate untouched.
            ST_ESCY_COL: if (accept) begin
                state_n = ST_IDLE;
                if (esc_row <= {2'b00, LAST_ROW})
                    cur_row_n = esc_row[4:0];
                if (esc_arg <= LAST_COL)
                    cur_x_n = esc_arg;
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers; reset optionally starts the full-screen
    // erase so the RAM is blank before the first character.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cur_x     <= '0;
            cur_row   <= '0;
            topline   <= '0;
            esc_row   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            cur_x     <= cur_x_n;
            cur_row   <= cur_row_n;
            topline   <= topline_n;
            esc_row   <= esc_row_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_vt52_screen_ctrl.sv
// tb_vt52_screen_ctrl
// Self-checking bench for vt52_screen_ctrl: a table of single-character
// vectors with expected write/cursor values, plus hand-written sequences for
// the power-up clear, scroll, erase-line, erase-screen and mid-erase reset.
module tb_vt52_screen_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [6:0]  curX;
    logic [4:0]  curY;
    logic [4:0]  topline;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [6:0]  mem_wdata;
    logic        busy;

    int pass_count  = 0;
    int check_count = 0;

    logic [17:0] wr_q[$];
    logic [10:0] exp_q[$];

    typedef struct {
        logic [6:0]  ch;
        logic        we;
        logic [10:0] addr;
        logic [6:0]  data;
        logic [6:0]  x;
        logic [4:0]  y;
    } vec_t;

    vec_t vecs[$];

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    vt52_screen_ctrl #(
        .CLEAR_ON_RESET (1'b1),
        .BLANK          (7'h20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .curX       (curX),
        .curY       (curY),
        .topline    (topline),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy)
    );

    // Log every RAM write, sampled on the inactive edge.
    always @(negedge clock) begin
        if (mem_we)
            wr_q.push_back({mem_addr, mem_wdata});
    end

    function automatic logic [10:0] tbAddr(input int x, input int y);
        logic [6:0] xv;
        logic [4:0] yv;
        xv = 7'(x);
        yv = 5'(y);
        if (y >= 24 || x >= 64)
            return {yv[0], 2'b11, yv[2:1], yv[4:3], xv[3:0]};
        return {yv[0], yv[4:1], xv[5:0]};
    endfunction

    function automatic int tbPhys(input int top, input int row);
        return (top + row) % 24;
    endfunction

    function automatic vec_t mk(input int ch, input int we, input int addr,
                                input int data, input int x, input int y);
        vec_t v;
        v.ch   = 7'(ch);
        v.we   = (we != 0);
        v.addr = 11'(addr);
        v.data = 7'(data);
        v.x    = 7'(x);
        v.y    = 5'(y);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Waits (bounded) for char_ready, presents one character for one edge,
    // and returns at the sample point of the cycle after acceptance.
    task automatic applyStimulus(input logic [6:0] ch);
        int n;
        n = 0;
        while (!char_ready && n < 4000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!char_ready) begin
            check_count++;
            $display("[TB] FAIL ready before send 0x%0h: got 0, expected 1", ch);
        end
        char_in    = ch;
        char_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        char_valid = 1'b0;
    endtask

    // Counts sample points with char_ready low, starting at the current one.
    task automatic waitReady(input int budget, output int low);
        low = 0;
        while (!char_ready && low < budget) begin
            low++;
            @(negedge clock);
            #1;
        end
        checkOutput("ready within budget", char_ready, 1);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " curX"}, curX, 0);
        checkOutput({name, " curY"}, curY, 0);
        checkOutput({name, " topline"}, topline, 0);
        checkOutput({name, " mem_we"}, mem_we, 0);
        checkOutput({name, " mem_addr"}, mem_addr, 0);
        checkOutput({name, " mem_wdata"}, mem_wdata, 0);
        checkOutput({name, " char_ready"}, char_ready, 0);
        checkOutput({name, " busy"}, busy, 1);
    endtask

    task automatic checkWrites(input string name);
        int bad;
        bad = 0;
        checkOutput({name, " write count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== {exp_q[i], 7'h20})
                bad++;
        checkOutput({name, " bad addr/data"}, bad, 0);
    endtask

    task automatic checkFullClear(input string name);
        bit seen[2048];
        int dups, missing, nonblank, low;
        dups     = 0;
        missing  = 0;
        nonblank = 0;
        waitReady(5000, low);
        checkOutput({name, " last write with ready"}, mem_we, 1);
        checkOutput({name, " write count"}, wr_q.size(), 1920);
        foreach (wr_q[i]) begin
            if (seen[wr_q[i][17:7]])
                dups++;
            seen[wr_q[i][17:7]] = 1'b1;
            if (wr_q[i][6:0] !== 7'h20)
                nonblank++;
        end
        for (int r = 0; r < 24; r++)
            for (int x = 0; x < 80; x++)
                if (!seen[tbAddr(x, r)])
                    missing++;
        checkOutput({name, " duplicate addrs"}, dups, 0);
        checkOutput({name, " non-blank data"}, nonblank, 0);
        checkOutput({name, " missing cells"}, missing, 0);
    endtask

    // Main sequence: power-up, table vectors, then multi-cycle corner cases.
    initial begin
        int low;
        int n;
        char_in    = 7'h00;
        char_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkReset("por");
        wr_q.delete();
        reset = 1'b0;
        checkFullClear("init clear");

        // ch, we, addr, data, curX, curY (topline stays 0 in this table)
        vecs.push_back(mk('h41, 1, 'h000, 'h41, 1, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 1, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 1, 0));
        vecs.push_back(mk('h22, 0, 0, 0, 1, 0));
        vecs.push_back(mk('h25, 0, 0, 0, 5, 2));
        vecs.push_back(mk('h42, 1, 'h045, 'h42, 6, 2));
        vecs.push_back(mk('h0D, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h08, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h61, 1, 'h040, 'h61, 1, 2));
        vecs.push_back(mk('h08, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h43, 0, 0, 0, 1, 2));
        vecs.push_back(mk('h1B, 0, 0, 0, 1, 2));
        vecs.push_back(mk('h44, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h44, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 2));
        vecs.push_back(mk('h41, 0, 0, 0, 0, 1));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 1));
        vecs.push_back(mk('h48, 0, 0, 0, 0, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 0, 0));
        vecs.push_back(mk('h20, 0, 0, 0, 0, 0));
        vecs.push_back(mk('h60, 0, 0, 0, 64, 0));
        vecs.push_back(mk('h51, 1, 'h300, 'h51, 65, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 65, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 65, 0));
        vecs.push_back(mk('h21, 0, 0, 0, 65, 0));
        vecs.push_back(mk('h20, 0, 0, 0, 0, 1));
        vecs.push_back(mk('h52, 1, 'h400, 'h52, 1, 1));
        vecs.push_back(mk('h1B, 0, 0, 0, 1, 1));
        vecs.push_back(mk('h59, 0, 0, 0, 1, 1));
        vecs.push_back(mk('h20, 0, 0, 0, 1, 1));
        vecs.push_back(mk('h6F, 0, 0, 0, 79, 0));
        vecs.push_back(mk('h58, 1, 'h30F, 'h58, 79, 0));
        vecs.push_back(mk('h59, 1, 'h30F, 'h59, 79, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 79, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 79, 0));
        vecs.push_back(mk('h38, 0, 0, 0, 79, 0));
        vecs.push_back(mk('h2A, 0, 0, 0, 10, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 10, 0));
        vecs.push_back(mk('h5A, 0, 0, 0, 10, 0));
        vecs.push_back(mk('h63, 1, 'h00A, 'h63, 11, 0));
        vecs.push_back(mk('h01, 0, 0, 0, 11, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 11, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 11, 0));
        vecs.push_back(mk('h0A, 0, 0, 0, 11, 0));
        vecs.push_back(mk('h0D, 0, 0, 0, 11, 0));
        vecs.push_back(mk('h64, 1, 'h00B, 'h64, 12, 0));
        vecs.push_back(mk('h1B, 0, 0, 0, 12, 0));
        vecs.push_back(mk('h59, 0, 0, 0, 12, 0));
        vecs.push_back(mk('h37, 0, 0, 0, 12, 0));
        vecs.push_back(mk('h20, 0, 0, 0, 0, 23));
        vecs.push_back(mk('h1B, 0, 0, 0, 0, 23));
        vecs.push_back(mk('h42, 0, 0, 0, 0, 23));
        vecs.push_back(mk('h7E, 1, 'h6C0, 'h7E, 1, 23));
        vecs.push_back(mk('h7F, 0, 0, 0, 1, 23));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ch);
            checkOutput($sformatf("vec%0d mem_we", i), mem_we, vecs[i].we);
            if (vecs[i].we) begin
                checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
                checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].data);
            end
            checkOutput($sformatf("vec%0d curX", i), curX, vecs[i].x);
            checkOutput($sformatf("vec%0d curY", i), curY, vecs[i].y);
        end
        checkOutput("table topline", topline, 0);

        // Line feed on the bottom row scrolls and blanks the old top row.
        wr_q.delete();
        exp_q.delete();
        applyStimulus(7'h0A);
        checkOutput("scroll topline", topline, 1);
        checkOutput("scroll curY", curY, tbPhys(1, 23));
        checkOutput("scroll curX", curX, 1);
        waitReady(300, low);
        checkOutput("scroll busy cycles", low, 80);
        checkOutput("scroll last write with ready", mem_we, 1);
        for (int x = 0; x < 80; x++)
            exp_q.push_back(tbAddr(x, 0));
        checkWrites("scroll");

        // Erase to end of line from column 70 of logical row 23.
        applyStimulus(7'h1B);
        applyStimulus(7'h59);
        applyStimulus(7'h37);
        applyStimulus(7'h66);
        checkOutput("eol setup curX", curX, 70);
        wr_q.delete();
        exp_q.delete();
        applyStimulus(7'h1B);
        applyStimulus(7'h4B);
        waitReady(200, low);
        checkOutput("eol busy cycles", low, 10);
        for (int x = 70; x < 80; x++)
            exp_q.push_back(tbAddr(x, tbPhys(1, 23)));
        checkWrites("eol");
        checkOutput("eol curX kept", curX, 70);
        checkOutput("eol curY kept", curY, tbPhys(1, 23));

        // Erase to end of screen from logical row 22, column 0.
        applyStimulus(7'h1B);
        applyStimulus(7'h59);
        applyStimulus(7'h36);
        applyStimulus(7'h20);
        checkOutput("eos setup curY", curY, tbPhys(1, 22));
        wr_q.delete();
        exp_q.delete();
        applyStimulus(7'h1B);
        applyStimulus(7'h4A);
        waitReady(400, low);
        checkOutput("eos busy cycles", low, 160);
        for (int r = 22; r < 24; r++)
            for (int x = 0; x < 80; x++)
                exp_q.push_back(tbAddr(x, tbPhys(1, r)));
        checkWrites("eos");
        checkOutput("eos curX kept", curX, 0);

        // Reset in the middle of an erase restarts the full power-up clear.
        wr_q.delete();
        applyStimulus(7'h1B);
        applyStimulus(7'h4A);
        n = 0;
        while (wr_q.size() < 50 && n < 400) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("mid-erase write count", wr_q.size(), 50);
        reset = 1'b1;
        #1;
        checkReset("mid-erase reset");
        repeat (2) @(negedge clock);
        #1;
        wr_q.delete();
        reset = 1'b0;
        checkFullClear("reclear");

        applyStimulus(7'h5A);
        checkOutput("post-reclear mem_we", mem_we, 1);
        checkOutput("post-reclear mem_addr", mem_addr, 0);
        checkOutput("post-reclear mem_wdata", mem_wdata, 7'h5A);
        checkOutput("post-reclear curX", curX, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
